// File: rtl/magia_stdio_monitor_if.sv
// Snooped AXI AW/W channels of one tile plus the byte stream that carries whole stdio lines out.
interface magia_stdio_monitor_if #(
    parameter int unsigned ID_W   = 2,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic                  aw_valid_i;
    logic                  aw_ready_i;
    logic [ADDR_W-1:0]     aw_addr_i;
    logic [ID_W-1:0]       aw_id_i;
    logic                  w_valid_i;
    logic                  w_ready_i;
    logic [DATA_W-1:0]     w_data_i;
    logic [DATA_W/8-1:0]   w_strb_i;
    logic                  w_last_i;
    logic                  out_valid_o;
    logic                  out_ready_i;
    logic [7:0]            out_data_o;
    logic [ID_W-1:0]       out_id_o;
    logic                  out_last_o;

    modport master (
        output aw_valid_i, aw_ready_i, aw_addr_i, aw_id_i,
        output w_valid_i, w_ready_i, w_data_i, w_strb_i, w_last_i,
        output out_ready_i,
        input  out_valid_o, out_data_o, out_id_o, out_last_o
    );

    modport slave (
        input  aw_valid_i, aw_ready_i, aw_addr_i, aw_id_i,
        input  w_valid_i, w_ready_i, w_data_i, w_strb_i, w_last_i,
        input  out_ready_i,
        output out_valid_o, out_data_o, out_id_o, out_last_o
    );
endinterface

// File: rtl/magia_stdio_monitor.sv
// Passive snoop of a tile's AXI write channels: collects per-ID stdio lines and the stderr
// exit code, and streams completed lines out one byte per cycle.
module magia_stdio_monitor #(
    parameter int unsigned       ID_W        = 2,
    parameter int unsigned       ADDR_W      = 32,
    parameter int unsigned       DATA_W      = 32,
    parameter logic [ADDR_W-1:0] STDERR_ADDR = 32'hFFFF0000,
    parameter logic [ADDR_W-1:0] STDIO_BASE  = 32'hFFFF0004,
    parameter int unsigned       LINE_DEPTH  = 64,
    parameter int unsigned       PEND_DEPTH  = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] hart_id_i,
    magia_stdio_monitor_if.slave bus,
    output logic        err_valid_o,
    output logic [7:0]  err_code_o,
    output logic [15:0] drop_cnt_o,
    output logic        pend_ovf_o
);

    localparam int unsigned N_IDS = 1 << ID_W;
    localparam int unsigned CNT_W = $clog2(LINE_DEPTH);
    localparam int unsigned CW    = CNT_W + 1;
    localparam int unsigned PTR_W = $clog2(PEND_DEPTH);

    typedef enum logic [1:0] {CLS_SKIP, CLS_OUT, CLS_ERR} cls_e;
    typedef enum logic [1:0] {BUF_FILL, BUF_READY, BUF_DRAIN} buf_state_e;

    // Pending AW entries waiting for their W bursts
    cls_e              pend_cls_q [PEND_DEPTH];
    logic [ID_W-1:0]   pend_id_q  [PEND_DEPTH];
    logic [PTR_W:0]    wr_ptr_q, rd_ptr_q;
    logic              pend_empty, pend_full;

    // Line buffers
    logic [7:0]        line_mem [N_IDS][LINE_DEPTH];
    logic [CW-1:0]     cnt_q    [N_IDS];
    buf_state_e        state_q  [N_IDS];
    buf_state_e        state_d  [N_IDS];

    // Output / arbiter
    logic              out_valid_q, out_last_q;
    logic [7:0]        out_data_q;
    logic [ID_W-1:0]   out_id_q;
    logic [CW-1:0]     rd_idx_q;
    logic [ID_W-1:0]   rr_ptr_q;

    logic              err_valid_q, pend_ovf_q;
    logic [7:0]        err_code_q;
    logic [15:0]       drop_cnt_q;

    logic [ADDR_W-1:0] stdio_addr;
    cls_e              aw_cls, cur_cls;
    logic [ID_W-1:0]   cur_id, grant_id, cand;
    logic [7:0]        wr_byte;
    logic              aw_hs, w_hs, bypass, beat_ok, push, pop, ovf_set;
    logic              is_char, append, drop, err_upd, grant_vld, out_take, line_done;

    logic              unused_ok;
    assign unused_ok = ^{bus.w_data_i, bus.w_strb_i};

    assign stdio_addr = STDIO_BASE + (ADDR_W'(hart_id_i) << 2);
    assign pend_empty = (wr_ptr_q == rd_ptr_q);
    assign pend_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                        (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

    always_comb begin
        aw_cls = CLS_SKIP;
        if (bus.aw_addr_i == stdio_addr) begin
            aw_cls = CLS_OUT;
        end else if (bus.aw_addr_i == STDERR_ADDR) begin
            aw_cls = CLS_ERR;
        end
    end

    // Beat routing: an AW arriving with W on an empty FIFO is used directly, and is only
    // queued if its burst continues past this beat.
    always_comb begin
        aw_hs     = bus.aw_valid_i & bus.aw_ready_i;
        w_hs      = bus.w_valid_i & bus.w_ready_i;
        bypass    = w_hs & pend_empty & aw_hs;
        cur_cls   = bypass ? aw_cls : pend_cls_q[rd_ptr_q[PTR_W-1:0]];
        cur_id    = bypass ? bus.aw_id_i : pend_id_q[rd_ptr_q[PTR_W-1:0]];
        beat_ok   = w_hs & (bypass | ~pend_empty);
        push      = aw_hs & ~pend_full & ~(bypass & bus.w_last_i);
        ovf_set   = aw_hs & pend_full;
        pop       = w_hs & ~pend_empty & bus.w_last_i;
        wr_byte   = bus.w_data_i[7:0];
        is_char   = beat_ok & (cur_cls == CLS_OUT) & bus.w_strb_i[0];
        err_upd   = beat_ok & (cur_cls == CLS_ERR) & bus.w_strb_i[0];
        append    = is_char & (state_q[cur_id] == BUF_FILL);
        drop      = (is_char & ~append) | (w_hs & ~beat_ok);
        out_take  = out_valid_q & bus.out_ready_i;
        line_done = out_take & out_last_q;
    end

    // Round-robin grant, searching from the id after the last one granted
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = rr_ptr_q;
        cand      = rr_ptr_q;
        if (!out_valid_q) begin
            for (int unsigned k = 1; k <= N_IDS; k++) begin
                cand = rr_ptr_q + ID_W'(k);
                if (!grant_vld && state_q[cand] == BUF_READY) begin
                    grant_vld = 1'b1;
                    grant_id  = cand;
                end
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < N_IDS; i++) begin
            state_d[i] = state_q[i];
            case (state_q[i])
                BUF_FILL: begin
                    if (append && cur_id == ID_W'(i) &&
                        (wr_byte == 8'h0A || cnt_q[i] == CW'(LINE_DEPTH - 1))) begin
                        state_d[i] = BUF_READY;
                    end
                end
                BUF_READY: begin
                    if (grant_vld && grant_id == ID_W'(i)) begin
                        state_d[i] = BUF_DRAIN;
                    end
                end
                BUF_DRAIN: begin
                    if (line_done && out_id_q == ID_W'(i)) begin
                        state_d[i] = BUF_FILL;
                    end
                end
                default: state_d[i] = BUF_FILL;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (append) begin
            line_mem[cur_id][cnt_q[cur_id][CNT_W-1:0]] <= wr_byte;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < N_IDS; i++) begin
                state_q[i] <= BUF_FILL;
                cnt_q[i]   <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < N_IDS; i++) begin
                state_q[i] <= state_d[i];
                if (append && cur_id == ID_W'(i)) begin
                    cnt_q[i] <= cnt_q[i] + CW'(1);
                end else if (line_done && out_id_q == ID_W'(i)) begin
                    cnt_q[i] <= '0;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < PEND_DEPTH; i++) begin
                pend_cls_q[i] <= CLS_SKIP;
                pend_id_q[i]  <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) begin
                pend_cls_q[wr_ptr_q[PTR_W-1:0]] <= aw_cls;
                pend_id_q[wr_ptr_q[PTR_W-1:0]]  <= bus.aw_id_i;
                wr_ptr_q <= wr_ptr_q + (PTR_W+1)'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + (PTR_W+1)'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_valid_q <= 1'b0;
            err_code_q  <= 8'hFF;
            drop_cnt_q  <= '0;
            pend_ovf_q  <= 1'b0;
        end else begin
            if (err_upd) begin
                err_valid_q <= 1'b1;
                err_code_q  <= wr_byte;
            end
            if (drop && drop_cnt_q != 16'hFFFF) begin
                drop_cnt_q <= drop_cnt_q + 16'd1;
            end
            if (ovf_set) begin
                pend_ovf_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_id_q    <= '0;
            out_last_q  <= 1'b0;
            rd_idx_q    <= '0;
            rr_ptr_q    <= '0;
        end else if (grant_vld) begin
            out_valid_q <= 1'b1;
            out_data_q  <= line_mem[grant_id][0];
            out_id_q    <= grant_id;
            out_last_q  <= (cnt_q[grant_id] == CW'(1));
            rd_idx_q    <= CW'(1);
            rr_ptr_q    <= grant_id;
        end else if (out_take) begin
            if (out_last_q) begin
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
            end else begin
                out_data_q <= line_mem[out_id_q][rd_idx_q[CNT_W-1:0]];
                out_last_q <= (rd_idx_q == cnt_q[out_id_q] - CW'(1));
                rd_idx_q   <= rd_idx_q + CW'(1);
            end
        end
    end

    assign bus.out_valid_o = out_valid_q;
    assign bus.out_data_o  = out_data_q;
    assign bus.out_id_o    = out_id_q;
    assign bus.out_last_o  = out_last_q;
    assign err_valid_o     = err_valid_q;
    assign err_code_o      = err_code_q;
    assign drop_cnt_o      = drop_cnt_q;
    assign pend_ovf_o      = pend_ovf_q;

endmodule

// File: tb/tb_magia_stdio_monitor.sv
// Directed bench for magia_stdio_monitor: hart 3, stdio at 0xFFFF0010, default parameters.
module tb_magia_stdio_monitor;

    logic        clk;
    logic        rst_ni;
    logic [31:0] hart_id;
    logic        err_valid;
    logic [7:0]  err_code;
    logic [15:0] drop_cnt;
    logic        pend_ovf;

    int unsigned total = 0;
    int unsigned bad   = 0;

    logic [7:0]  q_data [$];
    logic [1:0]  q_id   [$];
    logic        q_last [$];

    localparam logic [31:0] STDIO = 32'hFFFF0010;
    localparam logic [31:0] SERR  = 32'hFFFF0000;

    magia_stdio_monitor_if #(.ID_W(2), .ADDR_W(32), .DATA_W(32)) bus ();

    magia_stdio_monitor #(
        .ID_W(2), .ADDR_W(32), .DATA_W(32),
        .STDERR_ADDR(32'hFFFF0000), .STDIO_BASE(32'hFFFF0004),
        .LINE_DEPTH(64), .PEND_DEPTH(4)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni), .hart_id_i(hart_id), .bus(bus),
        .err_valid_o(err_valid), .err_code_o(err_code),
        .drop_cnt_o(drop_cnt), .pend_ovf_o(pend_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Byte accepted at the next posedge is recorded half a cycle earlier
    initial forever begin
        @(negedge clk);
        #1;
        if (rst_ni && bus.out_valid_o && bus.out_ready_i) begin
            q_data.push_back(bus.out_data_o);
            q_id.push_back(bus.out_id_o);
            q_last.push_back(bus.out_last_o);
        end
    end

    task automatic clear_q();
        q_data.delete();
        q_id.delete();
        q_last.delete();
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic aw_beat(input logic [31:0] a, input logic [1:0] id);
        bus.aw_valid_i = 1'b1; bus.aw_ready_i = 1'b1;
        bus.aw_addr_i  = a;    bus.aw_id_i    = id;
        @(negedge clk);
        bus.aw_valid_i = 1'b0;
    endtask

    task automatic w_beat(input logic [7:0] d, input logic last);
        bus.w_valid_i = 1'b1; bus.w_ready_i = 1'b1;
        bus.w_data_i  = {24'hABCDEF, d}; bus.w_strb_i = 4'hF; bus.w_last_i = last;
        @(negedge clk);
        bus.w_valid_i = 1'b0;
    endtask

    task automatic aw_w_beat(input logic [31:0] a, input logic [1:0] id, input logic [7:0] d,
                             input logic last);
        bus.aw_valid_i = 1'b1; bus.aw_ready_i = 1'b1;
        bus.aw_addr_i  = a;    bus.aw_id_i    = id;
        bus.w_valid_i  = 1'b1; bus.w_ready_i  = 1'b1;
        bus.w_data_i   = {24'h0, d}; bus.w_strb_i = 4'hF; bus.w_last_i = last;
        @(negedge clk);
        bus.aw_valid_i = 1'b0;
        bus.w_valid_i  = 1'b0;
    endtask

    task automatic wait_bytes(input string tag, input int unsigned n);
        int unsigned c = 0;
        while (q_data.size() < n && c < 300) begin
            @(negedge clk);
            c++;
        end
        idle(2);
        chk(tag, q_data.size(), n);
    endtask

    task automatic chk_byte(input string tag, input int unsigned k, input logic [7:0] d,
                            input logic [1:0] id, input logic last);
        if (k < q_data.size()) begin
            chk({tag, "_data"}, q_data[k], d);
            chk({tag, "_id"},   q_id[k],   id);
            chk({tag, "_last"}, q_last[k], last);
        end else begin
            chk({tag, "_missing"}, q_data.size(), k + 1);
        end
    endtask

    initial begin
        int unsigned n_last;
        rst_ni = 1'b0; hart_id = 32'd3;
        bus.aw_valid_i = 0; bus.aw_ready_i = 0; bus.aw_addr_i = '0; bus.aw_id_i = '0;
        bus.w_valid_i = 0; bus.w_ready_i = 0; bus.w_data_i = '0; bus.w_strb_i = '0;
        bus.w_last_i = 0; bus.out_ready_i = 1'b1;
        idle(3);
        rst_ni = 1'b1;
        idle(1);

        chk("rst_out_valid", bus.out_valid_o, 0);
        chk("rst_err_valid", err_valid, 0);
        chk("rst_err_code", err_code, 8'hFF);
        chk("rst_drop", drop_cnt, 0);
        chk("rst_ovf", pend_ovf, 0);

        // T1: queued AW then a three-beat burst; also checks newline-to-valid latency
        clear_q();
        aw_beat(STDIO, 2'd1);
        w_beat(8'h48, 1'b0);
        w_beat(8'h69, 1'b0);
        w_beat(8'h0A, 1'b1);
        chk("t1_ready_cycle_valid", bus.out_valid_o, 0);
        @(negedge clk);
        chk("t1_first_valid", bus.out_valid_o, 1);
        wait_bytes("t1_count", 3);
        chk_byte("t1_b0", 0, 8'h48, 2'd1, 1'b0);
        chk_byte("t1_b1", 1, 8'h69, 2'd1, 1'b0);
        chk_byte("t1_b2", 2, 8'h0A, 2'd1, 1'b1);

        // T2: id0 "A" (bypass), id2 "B\n", id0 "\n" -> id2 line drains first
        clear_q();
        aw_w_beat(STDIO, 2'd0, 8'h41, 1'b1);
        aw_beat(STDIO, 2'd2);
        w_beat(8'h42, 1'b0);
        w_beat(8'h0A, 1'b1);
        aw_beat(STDIO, 2'd0);
        w_beat(8'h0A, 1'b1);
        wait_bytes("t2_count", 4);
        chk_byte("t2_b0", 0, 8'h42, 2'd2, 1'b0);
        chk_byte("t2_b1", 1, 8'h0A, 2'd2, 1'b1);
        chk_byte("t2_b2", 2, 8'h41, 2'd0, 1'b0);
        chk_byte("t2_b3", 3, 8'h0A, 2'd0, 1'b1);

        // T3: 64 bytes without newline force the line out
        clear_q();
        aw_beat(STDIO, 2'd0);
        for (int unsigned i = 0; i < 64; i++) begin
            w_beat(8'h20 + 8'(i), i == 63);
        end
        wait_bytes("t3_count", 64);
        n_last = 0;
        for (int unsigned i = 0; i < q_data.size(); i++) begin
            chk("t3_data", q_data[i], 8'h20 + 8'(i));
            if (q_last[i]) n_last++;
        end
        chk("t3_last_count", n_last, 1);
        chk_byte("t3_b63", 63, 8'h5F, 2'd0, 1'b1);

        // T4: stalled output, three more chars to the draining buffer are dropped
        clear_q();
        bus.out_ready_i = 1'b0;
        aw_beat(STDIO, 2'd0);
        w_beat(8'h51, 1'b0);
        w_beat(8'h0A, 1'b1);
        idle(2);
        chk("t4_valid_stall", bus.out_valid_o, 1);
        aw_beat(STDIO, 2'd0);
        w_beat(8'h61, 1'b0);
        w_beat(8'h62, 1'b0);
        w_beat(8'h63, 1'b1);
        idle(1);
        chk("t4_drop", drop_cnt, 3);
        chk("t4_hold_valid", bus.out_valid_o, 1);
        chk("t4_hold_data", bus.out_data_o, 8'h51);
        chk("t4_hold_id", bus.out_id_o, 0);
        chk("t4_hold_last", bus.out_last_o, 0);
        bus.out_ready_i = 1'b1;
        wait_bytes("t4_count", 2);
        chk_byte("t4_b0", 0, 8'h51, 2'd0, 1'b0);
        chk_byte("t4_b1", 1, 8'h0A, 2'd0, 1'b1);

        // T5: stderr code, skipped address, orphan W beat
        clear_q();
        aw_beat(SERR, 2'd1);
        chk("t5_err_before", err_valid, 0);
        w_beat(8'h2A, 1'b1);
        chk("t5_err_valid", err_valid, 1);
        chk("t5_err_code", err_code, 8'h2A);
        aw_beat(32'h0000_1000, 2'd3);
        w_beat(8'h78, 1'b1);
        idle(4);
        chk("t5_skip_no_out", q_data.size(), 0);
        chk("t5_skip_no_drop", drop_cnt, 3);
        w_beat(8'h79, 1'b1);
        chk("t5_orphan_drop", drop_cnt, 4);
        chk("t5_err_code_kept", err_code, 8'h2A);

        // T6: pending overflow, then asynchronous reset in the middle of a drain
        bus.out_ready_i = 1'b0;
        aw_w_beat(STDIO, 2'd1, 8'h0A, 1'b1);
        idle(2);
        chk("t6_draining", bus.out_valid_o, 1);
        for (int unsigned i = 0; i < 4; i++) aw_beat(32'h0000_2000, 2'(i));
        chk("t6_ovf_at4", pend_ovf, 0);
        aw_beat(32'h0000_2000, 2'd0);
        chk("t6_ovf_at5", pend_ovf, 1);
        #2 rst_ni = 1'b0;
        #1;
        chk("t6_rst_valid", bus.out_valid_o, 0);
        chk("t6_rst_last", bus.out_last_o, 0);
        chk("t6_rst_err_valid", err_valid, 0);
        chk("t6_rst_err_code", err_code, 8'hFF);
        chk("t6_rst_drop", drop_cnt, 0);
        chk("t6_rst_ovf", pend_ovf, 0);
        idle(2);
        rst_ni = 1'b1;
        bus.out_ready_i = 1'b1;
        idle(3);
        chk("t6_post_valid", bus.out_valid_o, 0);

        // After reset the monitor works again from a clean state
        clear_q();
        aw_w_beat(STDIO, 2'd3, 8'h6B, 1'b0);
        w_beat(8'h0A, 1'b1);
        wait_bytes("t6_post_count", 2);
        chk_byte("t6_post_b0", 0, 8'h6B, 2'd3, 1'b0);
        chk_byte("t6_post_b1", 1, 8'h0A, 2'd3, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
